audio_word_fetcher: RTL and testbench
=====================================

# audio_word_fetcher

Upstream feeder for the audio serializer. Walks a configurable address range in sample memory, fetches 16-bit words over a request/valid memory port into a small prefetch buffer, and presents one word per serializer `done` pulse. Generates the serializer's `enable` (`playing`), handles loop/one-shot playback, stop and underrun, and hides arbitrary memory read latency.

## Interface
- `ADDR_W`, 16, sample-memory word-address width
- `DATA_W`, 16, sample word width
- `DEPTH`, 2, prefetch buffer entries (≥2, power of two)

- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `start`  in  1  pulse; begins playback, honoured only in IDLE
- `stop`  in  1  pulse; aborts playback from any state
- `loop`  in  1  latched on `start`; 1 = wrap to `start_addr` after `end_addr`
- `start_addr`  in  ADDR_W  first word address, latched on `start`
- `end_addr`  in  ADDR_W  last word address (inclusive), latched on `start`
- `mem_rd_en`  out  1  one-cycle read request
- `mem_addr`  out  ADDR_W  read address, valid with `mem_rd_en`
- `mem_rd_valid`  in  1  one-cycle read-data strobe, ≥1 cycle after request
- `mem_rd_data`  in  DATA_W  read data, valid with `mem_rd_valid`
- `word_take`  in  1  serializer `done`; consumes the head word
- `data_out`  out  DATA_W  head word to serializer `data_in`
- `playing`  out  1  serializer enable
- `finished`  out  1  one-cycle pulse at end of one-shot clip
- `underrun`  out  1  sticky; set on `word_take` with empty buffer, cleared on `start`

## Operation
- FSM: IDLE → PRIME on `start`; PRIME → RUN when buffer count == DEPTH or the last clip word has been written; RUN → IDLE when one-shot, last word fetched, buffer empty, no read outstanding; any state → IDLE on `stop`.
- Fetch rule: issue `mem_rd_en` in PRIME/RUN when (count + outstanding) < DEPTH and fetch not exhausted. At most one read outstanding; no new request in the cycle its `mem_rd_valid` arrives unless the slot condition still holds with the arriving word counted.
- Address: `cur_addr` starts at `start_addr`; after requesting `end_addr`: loop → `start_addr`, one-shot → fetch exhausted. Otherwise `cur_addr + 1` modulo 2^ADDR_W; `end_addr < start_addr` wraps through 0. `start_addr == end_addr` = single-word clip.
- Buffer: circular FIFO, write on `mem_rd_valid`, pop on `word_take` when non-empty. Simultaneous push and pop at full is legal (count unchanged).
- `data_out` = head entry when non-empty, else 16'h0000 (silence).
- `word_take` when empty in RUN: no pop, `underrun` set. `word_take` outside RUN ignored.
- `stop`: buffer flushed, `playing` low next cycle; a read still outstanding is tracked and its `mem_rd_valid` discarded. `start` in the same cycle as `stop`: `stop` wins. New `start` is accepted only after the discarded response has returned.
- `finished` pulses in the cycle of the RUN → IDLE transition; never on `stop`.

## Timing
- Reset values: `mem_rd_en`=0, `mem_addr`=0, `data_out`=0, `playing`=0, `finished`=0, `underrun`=0; FSM IDLE, buffer empty.
- All outputs registered.
- `start` at edge N → first `mem_rd_en` high in cycle N+1.
- `playing` rises the cycle after the PRIME → RUN condition is met.
- `word_take` sampled at edge N → new head on `data_out` after edge N (visible in cycle N+1).
- `mem_rd_valid` at edge N with buffer previously empty → `data_out` valid in cycle N+1.

## Structure
- Package `audio_pkg`: FSM state enum (IDLE, PRIME, RUN), silence word constant, default widths shared with the serializer.
- One sub-module: `sample_fifo` (parameterised DEPTH×DATA_W circular buffer with count, push/pop, full/empty). FSM, address counter and outstanding/discard tracking in the top.

## Test plan
- One-shot, start_addr=0x0010, end_addr=0x0013, latency 1, `word_take` every 16 cycles → words from 0x10..0x13 in order, `finished` one pulse after fourth take, `playing` then 0, `underrun`=0.
- Loop, 0x0000..0x0002, latency 3 → output sequence 0,1,2,0,1,2…; no `finished`; `mem_addr` never exceeds 0x0002.
- Wrap: start_addr=0xFFFE, end_addr=0x0001, one-shot → requests 0xFFFE,0xFFFF,0x0000,0x0001, then exhausted.
- Underrun: latency 20, `word_take` every 4 cycles → `underrun`=1, `data_out`=0x0000 on empty takes; next `start` clears it.
- `stop` with read outstanding → `playing` low next cycle, late `mem_rd_valid` not written (count stays 0), `start` during pending response ignored, accepted after.
- `reset` asserted mid-RUN, asynchronous to clock → all outputs 0 immediately; after release, IDLE, no `mem_rd_en` until `start`.

Source files
------------

// File: rtl/audio_pkg.sv
// audio_pkg: shared types and constants for the audio word fetcher and the
// serializer it feeds.
//   - fetch_state_t : fetcher FSM states (IDLE, PRIME, RUN)
//   - SILENCE_WORD  : word presented to the serializer when nothing is buffered
//   - AUDIO_ADDR_W / AUDIO_DATA_W / FETCH_DEPTH : default widths and buffer depth
package audio_pkg;

    localparam int AUDIO_ADDR_W = 16;
    localparam int AUDIO_DATA_W = 16;
    localparam int FETCH_DEPTH  = 2;

    localparam logic [AUDIO_DATA_W-1:0] SILENCE_WORD = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: DEPTH x DATA_W circular prefetch buffer.
// Ports:
//   clock, reset   - rising-edge clock, async active-high reset
//   flush          - empties the buffer (wins over push/pop)
//   push, wdata    - write a word; dropped when full unless popping the same cycle
//   pop            - consume the head word; ignored when empty
//   head           - registered head word, SILENCE_WORD when empty
//   count_next     - occupancy after this cycle's push/pop/flush
//   full, empty    - current occupancy flags
module sample_fifo
    import audio_pkg::*;
#(
    parameter int DEPTH  = FETCH_DEPTH,
    parameter int DATA_W = AUDIO_DATA_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wdata,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic [$clog2(DEPTH):0]   count_next,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr, rd_ptr_next;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head_next;
    logic              do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // DEPTH is a power of two, so pointers wrap naturally
    assign rd_ptr_next = do_pop ? rd_ptr + 1'b1 : rd_ptr;

    always_comb begin
        count_next = count;
        if (flush)
            count_next = '0;
        else if (do_push && !do_pop)
            count_next = count + 1'b1;
        else if (do_pop && !do_push)
            count_next = count - 1'b1;
    end

    // Head is registered; when the slot becoming head is the one written
    // this cycle, forward the incoming word instead of the stale entry.
    always_comb begin
        head_next = DATA_W'(SILENCE_WORD);
        if (count_next != '0)
            head_next = (do_push && (wr_ptr == rd_ptr_next)) ? wdata : mem[rd_ptr_next];
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            head   <= DATA_W'(SILENCE_WORD);
        end else begin
            count <= count_next;
            head  <= head_next;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                rd_ptr <= rd_ptr_next;
                if (do_push)
                    wr_ptr <= wr_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/audio_word_fetcher.sv
// audio_word_fetcher: walks [start_addr..end_addr] in sample memory, prefetches
// words into a small buffer and hands one word to the serializer per done pulse.
// Ports:
//   clock, reset            - rising-edge clock, async active-high reset
//   start, stop, loop       - playback control (loop/addresses latched on start)
//   start_addr, end_addr    - inclusive word-address range, may wrap through 0
//   mem_rd_en, mem_addr     - one-cycle read request
//   mem_rd_valid, mem_rd_data - read response, any latency >= 1 cycle
//   word_take               - serializer done; consumes data_out
//   data_out                - head word, silence when buffer empty
//   playing                 - serializer enable
//   finished                - one-cycle pulse when a one-shot clip drains
//   underrun                - sticky: a take found the buffer empty
module audio_word_fetcher
    import audio_pkg::*;
#(
    parameter int ADDR_W = AUDIO_ADDR_W,
    parameter int DATA_W = AUDIO_DATA_W,
    parameter int DEPTH  = FETCH_DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              loop,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W-1:0] end_addr,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              word_take,
    output logic [DATA_W-1:0] data_out,
    output logic              playing,
    output logic              finished,
    output logic              underrun
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t      state, state_next;
    logic [ADDR_W-1:0] cur_addr, first_addr, last_addr;
    logic [ADDR_W-1:0] fetch_addr, fetch_first, fetch_last;
    logic              loop_r, fetch_loop;
    logic              exhausted, fetch_blocked;
    logic              outstanding, outstanding_after, discard;
    logic              start_ok, push, pop, take_empty, issue, clip_done;
    logic [CNT_W-1:0]  count_next;
    logic              full, empty;

    // A start is refused while a read (possibly one being discarded) is in flight
    assign start_ok          = (state == IDLE) && start && !stop && !outstanding;
    assign push              = mem_rd_valid && outstanding && !discard;
    assign pop               = word_take && (state == RUN);
    assign take_empty        = word_take && (state == RUN) && empty;
    assign outstanding_after = outstanding && !mem_rd_valid;

    sample_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (stop),
        .push       (push),
        .wdata      (mem_rd_data),
        .pop        (pop),
        .head       (data_out),
        .count_next (count_next),
        .full       (full),
        .empty      (empty)
    );

    always_comb begin
        state_next = state;
        clip_done  = 1'b0;
        case (state)
            IDLE:    if (start_ok) state_next = PRIME;
            PRIME:   if (full || (exhausted && !outstanding)) state_next = RUN;
            RUN: begin
                if (!loop_r && exhausted && empty && !outstanding) begin
                    state_next = IDLE;
                    clip_done  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
        if (stop) begin
            state_next = IDLE;
            clip_done  = 1'b0;
        end
    end

    // On the start edge the latched range is not yet loaded, so fetch from the ports
    always_comb begin
        fetch_addr    = (state == IDLE) ? start_addr : cur_addr;
        fetch_first   = (state == IDLE) ? start_addr : first_addr;
        fetch_last    = (state == IDLE) ? end_addr   : last_addr;
        fetch_loop    = (state == IDLE) ? loop       : loop_r;
        fetch_blocked = (state == IDLE) ? 1'b0       : exhausted;
        issue = (state_next != IDLE) && !fetch_blocked && !outstanding_after
                && (int'(count_next) < DEPTH);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cur_addr    <= '0;
            first_addr  <= '0;
            last_addr   <= '0;
            loop_r      <= 1'b0;
            exhausted   <= 1'b0;
            outstanding <= 1'b0;
            discard     <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            playing     <= 1'b0;
            finished    <= 1'b0;
            underrun    <= 1'b0;
        end else begin
            playing   <= (state_next == RUN);
            finished  <= clip_done;
            mem_rd_en <= issue;

            if (start_ok) begin
                first_addr <= start_addr;
                last_addr  <= end_addr;
                loop_r     <= loop;
                exhausted  <= 1'b0;
                underrun   <= 1'b0;
            end else if (take_empty) begin
                underrun <= 1'b1;
            end

            // Issue assignments come last so a single-word clip exhausts on the start edge
            if (issue) begin
                mem_addr <= fetch_addr;
                if (fetch_addr == fetch_last) begin
                    if (fetch_loop) cur_addr  <= fetch_first;
                    else            exhausted <= 1'b1;
                end else begin
                    cur_addr <= fetch_addr + 1'b1;
                end
            end

            if (issue)             outstanding <= 1'b1;
            else if (mem_rd_valid) outstanding <= 1'b0;

            // A read in flight at stop must still be absorbed, but not buffered
            if (stop && outstanding_after) discard <= 1'b1;
            else if (mem_rd_valid)         discard <= 1'b0;
        end
    end

endmodule

// File: tb/tb_audio_word_fetcher.sv
// Directed bench for audio_word_fetcher. Memory returns addr ^ 16'h5A00 after
// a programmable latency; inputs change and outputs are sampled on negedges.
module tb_audio_word_fetcher;

    logic        clock, reset, start, stop, loop;
    logic [15:0] start_addr, end_addr;
    logic        mem_rd_en, mem_rd_valid, word_take;
    logic [15:0] mem_addr, mem_rd_data, data_out;
    logic        playing, finished, underrun;

    int          tests, fails;
    int          lat;
    int          fin_cnt;
    logic [15:0] req_q[$];

    audio_word_fetcher dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .loop         (loop),
        .start_addr   (start_addr),
        .end_addr     (end_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_addr     (mem_addr),
        .mem_rd_valid (mem_rd_valid),
        .mem_rd_data  (mem_rd_data),
        .word_take    (word_take),
        .data_out     (data_out),
        .playing      (playing),
        .finished     (finished),
        .underrun     (underrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Sample memory: single outstanding read, response after lat cycles
    initial begin
        logic        pending;
        int          cnt;
        logic [15:0] pend_addr;
        pending = 1'b0; cnt = 0; pend_addr = '0;
        mem_rd_valid = 1'b0; mem_rd_data = '0;
        forever begin
            @(negedge clock);
            mem_rd_valid = 1'b0;
            if (reset) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    cnt--;
                    if (cnt == 0) begin
                        mem_rd_valid = 1'b1;
                        mem_rd_data  = pend_addr ^ 16'h5A00;
                        pending      = 1'b0;
                    end
                end
                if (mem_rd_en) begin
                    pending   = 1'b1;
                    cnt       = lat;
                    pend_addr = mem_addr;
                end
            end
        end
    end

    // Request log and finished-pulse counter
    initial begin
        fin_cnt = 0;
        forever begin
            @(negedge clock);
            if (mem_rd_en === 1'b1) req_q.push_back(mem_addr);
            if (finished === 1'b1) fin_cnt++;
        end
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_clip(input logic [15:0] sa, input logic [15:0] ea, input logic lp);
        start_addr = sa; end_addr = ea; loop = lp; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_playing(input string tag, input int bound);
        for (int i = 0; i < bound && playing !== 1'b1; i++) tick();
        check(tag, playing, 1'b1);
    endtask

    task automatic take_word(input string tag, input logic [15:0] exp);
        check(tag, data_out, exp);
        word_take = 1'b1;
        tick();
        word_take = 1'b0;
    endtask

    task automatic check_reqs(input string tag, input logic [15:0] exp_q[$]);
        check({tag, "_n"}, req_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            check($sformatf("%s_%0d", tag, i),
                  (i < req_q.size()) ? {16'h0, req_q[i]} : 32'hDEADBEEF, exp_q[i]);
    endtask

    initial begin
        int          fin_before;
        logic [15:0] max_addr;
        tests = 0; fails = 0; lat = 1;
        reset = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0;
        start_addr = '0; end_addr = '0; word_take = 1'b0;
        repeat (3) tick();

        // Reset state
        check("rst_rd_en",    mem_rd_en, 0);
        check("rst_addr",     mem_addr,  0);
        check("rst_data",     data_out,  0);
        check("rst_playing",  playing,   0);
        check("rst_finished", finished,  0);
        check("rst_underrun", underrun,  0);
        reset = 1'b0;
        repeat (5) tick();
        check("idle_no_req", req_q.size(), 0);

        // One-shot 0x10..0x13, latency 1
        lat = 1;
        start_clip(16'h0010, 16'h0013, 1'b0);
        check("first_req_en",   mem_rd_en, 1);
        check("first_req_addr", mem_addr,  16'h0010);
        wait_playing("os_playing", 50);
        for (int i = 0; i < 4; i++) begin
            repeat (16) tick();
            take_word($sformatf("os_word%0d", i), 16'h5A10 + 16'(i));
        end
        repeat (5) tick();
        check("os_finished", fin_cnt, 1);
        check("os_stopped",  playing, 0);
        check("os_underrun", underrun, 0);
        check("os_silence",  data_out, 0);
        check_reqs("os_reqs", '{16'h0010, 16'h0011, 16'h0012, 16'h0013});

        // Loop 0..2, latency 3, then stop from RUN
        lat = 3;
        req_q.delete();
        fin_before = fin_cnt;
        start_clip(16'h0000, 16'h0002, 1'b1);
        wait_playing("lp_playing", 50);
        for (int i = 0; i < 6; i++) begin
            repeat (8) tick();
            take_word($sformatf("lp_word%0d", i), 16'h5A00 + 16'(i % 3));
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_playing_low", playing, 0);
        check("stop_flush",       data_out, 0);
        repeat (10) tick();
        check("lp_no_finished", fin_cnt, fin_before);
        max_addr = '0;
        foreach (req_q[i]) if (req_q[i] > max_addr) max_addr = req_q[i];
        check("lp_max_addr", max_addr, 16'h0002);
        check("lp_wraps", (req_q.size() > 3) ? {16'h0, req_q[3]} : 32'hDEADBEEF, 16'h0000);

        // Address wrap through 0, one-shot
        lat = 1;
        req_q.delete();
        start_clip(16'hFFFE, 16'h0001, 1'b0);
        wait_playing("wr_playing", 50);
        take_word("wr_word0", 16'hA5FE);
        repeat (6) tick();
        take_word("wr_word1", 16'hA5FF);
        repeat (6) tick();
        take_word("wr_word2", 16'h5A00);
        repeat (6) tick();
        take_word("wr_word3", 16'h5A01);
        repeat (8) tick();
        check_reqs("wr_reqs", '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001});
        check("wr_finished", fin_cnt, fin_before + 1);

        // Underrun: slow memory, fast takes
        lat = 20;
        start_clip(16'h0020, 16'h0023, 1'b0);
        wait_playing("ur_playing", 100);
        take_word("ur_word0", 16'h5A20);
        repeat (3) tick();
        take_word("ur_word1", 16'h5A21);
        repeat (3) tick();
        take_word("ur_silence", 16'h0000);
        check("ur_set",         underrun, 1);
        check("ur_data_silent", data_out, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        repeat (30) tick();
        check("ur_sticky", underrun, 1);

        // Single-word clip; start clears underrun
        lat = 1;
        req_q.delete();
        fin_before = fin_cnt;
        start_clip(16'h0040, 16'h0040, 1'b0);
        check("ur_cleared", underrun, 0);
        wait_playing("sw_playing", 20);
        take_word("sw_word", 16'h5A40);
        repeat (4) tick();
        check("sw_finished", fin_cnt, fin_before + 1);
        check_reqs("sw_reqs", '{16'h0040});

        // Stop with a read outstanding; start refused until it returns
        lat = 10;
        start_clip(16'h0050, 16'h0057, 1'b0);
        repeat (2) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("so_playing", playing, 0);
        req_q.delete();
        start_clip(16'h0060, 16'h0061, 1'b0);
        check("so_start_ignored", mem_rd_en, 0);
        repeat (9) tick();
        check("so_stale_dropped", data_out, 0);
        check("so_no_reqs", req_q.size(), 0);
        lat = 1;
        start_clip(16'h0060, 16'h0061, 1'b0);
        check("so_restart_en",   mem_rd_en, 1);
        check("so_restart_addr", mem_addr,  16'h0060);
        wait_playing("so_playing2", 20);
        take_word("so_word0", 16'h5A60);
        repeat (4) tick();
        take_word("so_word1", 16'h5A61);
        repeat (4) tick();

        // Asynchronous reset mid-RUN
        start_clip(16'h0000, 16'h0002, 1'b1);
        wait_playing("ar_playing", 20);
        repeat (3) tick();
        check("ar_pre_head", data_out, 16'h5A00);
        #2 reset = 1'b1;
        #1;
        check("ar_playing_low", playing,   0);
        check("ar_data_zero",   data_out,  0);
        check("ar_rd_en_zero",  mem_rd_en, 0);
        check("ar_addr_zero",   mem_addr,  0);
        repeat (2) tick();
        reset = 1'b0;
        req_q.delete();
        repeat (6) tick();
        check("ar_no_req",  req_q.size(), 0);
        check("ar_idle",    playing, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
